id_regfile_sb: RTL and testbench
================================

ID_REGFILE_SB -- requirements
Module: id_regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NUM_REGS, default 32, architectural registers (power of 2, >=2); AW = clog2(NUM_REGS).
REQ-003 Parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 Parameter CNT_W, default 16, stall counter width.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 rd_id  in  NUM_RD*AW  source register index per read port.
REQ-008 rd_data  out  NUM_RD*XLEN  read data per port, combinational.
REQ-009 wb_en  in  1  writeback strobe.
REQ-010 wb_id  in  AW  writeback register index.
REQ-011 wb_data  in  XLEN  writeback data.
REQ-012 issue_valid  in  1  decoded instruction requests issue.
REQ-013 issue_has_rd  in  1  instruction writes a destination.
REQ-014 issue_rd  in  AW  destination index.
REQ-015 issue_ready  out  1  no hazard; issue accepted when issue_valid & issue_ready.
REQ-016 flush  in  1  pipeline flush; clears pending destinations.
REQ-017 busy  out  NUM_REGS  scoreboard bit per register.
REQ-018 stall_cnt  out  CNT_W  cycles with issue_valid & !issue_ready.
REQ-019 debug_reg  out  NUM_REGS*XLEN  flattened register file contents (registered).

Function
REQ-020 Register 0 SHALL always read 0, ignore writes, and never become busy.
REQ-021 rd_data[p] SHALL equal wb_data when wb_en & wb_id==rd_id[p] & rd_id[p]!=0 (same-cycle bypass), else stored value.
REQ-022 Write SHALL update storage at the clock edge when wb_en & wb_id!=0.
REQ-023 Hazard SHALL exist when any port p has busy[rd_id[p]] & !(wb_en & wb_id==rd_id[p]), or issue_has_rd & busy[issue_rd] & !(wb_en & wb_id==issue_rd) (WAW).
REQ-024 issue_ready SHALL be !hazard & !flush, combinational.
REQ-025 Accepted issue with issue_has_rd & issue_rd!=0 SHALL set busy[issue_rd] next cycle.
REQ-026 wb_en SHALL clear busy[wb_id] next cycle, unless same-cycle accepted issue targets the same index, in which case busy SHALL remain set.
REQ-027 flush SHALL clear all busy bits next cycle, overriding same-cycle issue; same-cycle writeback data SHALL still be written.
REQ-028 Writeback to a non-busy register SHALL be legal and write data.
REQ-029 stall_cnt SHALL increment on issue_valid & !issue_ready and saturate at all-ones (no wrap).
REQ-030 Read paths SHALL have zero latency; busy and debug_reg SHALL reflect state one cycle after an update.

Reset
REQ-031 During reset all registers, busy, stall_cnt and debug_reg SHALL be 0; issue_ready SHALL be 1 while issue ports are idle.
REQ-032 Reset asserted mid-operation SHALL discard pending writes and busy bits immediately (asynchronous).
REQ-033 First writeback SHALL be honoured on the first rising edge after reset deasserts.

Structure
REQ-034 XLEN default, REGISTER_FILE_SIZE and helper index types SHALL live in shared package common.
REQ-035 Scoreboard (busy set/clear/flush, hazard logic) SHALL be sub-module id_scoreboard; storage and bypass stay in the top.
REQ-036 No latches; single always_ff per state element group, asynchronous reset on reset.

Verification
REQ-037 Write x5=0xDEADBEEF, read rd_id0=5 same cycle -> rd_data0=0xDEADBEEF; next cycle still 0xDEADBEEF.
REQ-038 Write x0=0x1234, issue rd=0 -> rd_data=0, busy[0]=0, issue_ready=1.
REQ-039 Issue rd=7, next cycle issue with rd_id0=7 -> issue_ready=0, stall_cnt=1; wb x7=0x55 that cycle -> issue_ready=1, rd_data0=0x55.
REQ-040 busy[3]=1, same cycle wb x3 and issue rd=3 -> busy[3]=1 next cycle, register x3 holds wb_data.
REQ-041 busy[4]=busy[9]=1, assert flush with issue rd=2 -> busy all 0 next cycle, issue not accepted.
REQ-042 Hold stall for 2^CNT_W+3 cycles (CNT_W=4) -> stall_cnt=0xF; assert reset mid-stall -> stall_cnt=0, busy=0 immediately.

Source files
------------

// File: rtl/id_regfile_sb_pkg.sv
// Shared constants and types for the decode-stage register file and scoreboard.
package common;

    localparam int unsigned XLEN_DEFAULT       = 32;
    localparam int unsigned REGISTER_FILE_SIZE = 32;
    localparam int unsigned REG_AW             = $clog2(REGISTER_FILE_SIZE);

    typedef logic [REG_AW-1:0]       reg_idx_t;
    typedef logic [XLEN_DEFAULT-1:0] xword_t;

    // Why an issue is being held back; HZ_NONE means the issue can proceed.
    typedef enum logic [1:0] {
        HZ_NONE,
        HZ_RAW,
        HZ_WAW,
        HZ_FLUSH
    } hazard_e;

endpackage

// File: rtl/id_regfile_sb_scoreboard.sv
// Scoreboard: per-register pending-write bits, issue hazard detection and stall counting.
module id_scoreboard #(
    parameter  int unsigned NUM_REGS = common::REGISTER_FILE_SIZE,
    parameter  int unsigned NUM_RD   = 2,
    parameter  int unsigned CNT_W    = 16,
    localparam int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_RD*AW-1:0] rd_id,
    input  logic                 wb_en,
    input  logic [AW-1:0]        wb_id,
    input  logic                 issue_valid,
    input  logic                 issue_has_rd,
    input  logic [AW-1:0]        issue_rd,
    input  logic                 flush,
    output logic                 issue_ready,
    output logic [NUM_REGS-1:0]  busy,
    output logic [CNT_W-1:0]     stall_cnt
);
    import common::*;

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [AW-1:0]       src;
    logic                raw_hit;
    logic                waw_hit;
    logic                issue_fire;
    hazard_e             hz_cause;

    // A writeback landing this cycle resolves the dependency it would otherwise cause.
    always_comb begin
        raw_hit = 1'b0;
        src     = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            src = rd_id[p*AW +: AW];
            if (busy_q[src] && !(wb_en && wb_id == src)) begin
                raw_hit = 1'b1;
            end
        end
        waw_hit = issue_has_rd && busy_q[issue_rd] && !(wb_en && wb_id == issue_rd);

        if (flush) begin
            hz_cause = HZ_FLUSH;
        end else if (raw_hit) begin
            hz_cause = HZ_RAW;
        end else if (waw_hit) begin
            hz_cause = HZ_WAW;
        end else begin
            hz_cause = HZ_NONE;
        end
    end

    assign issue_ready = (hz_cause == HZ_NONE);
    assign issue_fire  = issue_valid && issue_ready;

    // Ordering matters: clear on writeback, then set on issue, then flush wins over both.
    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_id] = 1'b0;
        end
        if (issue_fire && issue_has_rd && issue_rd != '0) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (issue_valid && !issue_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign busy      = busy_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: rtl/id_regfile_sb.sv
// Decode-stage register file with same-cycle writeback bypass and an issue scoreboard.
module id_regfile_sb #(
    parameter  int unsigned XLEN     = common::XLEN_DEFAULT,
    parameter  int unsigned NUM_REGS = common::REGISTER_FILE_SIZE,
    parameter  int unsigned NUM_RD   = 2,
    parameter  int unsigned CNT_W    = 16,
    localparam int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_id,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    input  logic                     wb_en,
    input  logic [AW-1:0]            wb_id,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     issue_valid,
    input  logic                     issue_has_rd,
    input  logic [AW-1:0]            issue_rd,
    output logic                     issue_ready,
    input  logic                     flush,
    output logic [NUM_REGS-1:0]      busy,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [NUM_REGS*XLEN-1:0] debug_reg
);
    import common::*;

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];
    logic [AW-1:0]   rd_src;

    always_comb begin
        regs_d = regs_q;
        if (wb_en && wb_id != '0) begin
            regs_d[wb_id] = wb_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // x0 needs no special case on the stored path: its storage is pinned to zero.
    always_comb begin
        rd_data = '0;
        rd_src  = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            rd_src = rd_id[p*AW +: AW];
            if (wb_en && wb_id == rd_src && rd_src != '0) begin
                rd_data[p*XLEN +: XLEN] = wb_data;
            end else begin
                rd_data[p*XLEN +: XLEN] = regs_q[rd_src];
            end
        end
    end

    always_comb begin
        debug_reg = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            debug_reg[i*XLEN +: XLEN] = regs_q[i];
        end
    end

    id_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .CNT_W    (CNT_W)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .rd_id        (rd_id),
        .wb_en        (wb_en),
        .wb_id        (wb_id),
        .issue_valid  (issue_valid),
        .issue_has_rd (issue_has_rd),
        .issue_rd     (issue_rd),
        .flush        (flush),
        .issue_ready  (issue_ready),
        .busy         (busy),
        .stall_cnt    (stall_cnt)
    );

endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed bench for id_regfile_sb: bypass, x0, hazards, WAW hold, flush, stall saturation, async reset.
module tb_id_regfile_sb;

    logic          clk;
    logic          reset;
    logic [9:0]    rd_id;
    logic [63:0]   rd_data;
    logic          wb_en;
    logic [4:0]    wb_id;
    logic [31:0]   wb_data;
    logic          issue_valid;
    logic          issue_has_rd;
    logic [4:0]    issue_rd;
    logic          issue_ready;
    logic          flush;
    logic [31:0]   busy;
    logic [3:0]    stall_cnt;
    logic [1023:0] debug_reg;

    int total = 0;
    int bad   = 0;

    id_regfile_sb #(
        .XLEN     (32),
        .NUM_REGS (32),
        .NUM_RD   (2),
        .CNT_W    (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_id        (rd_id),
        .rd_data      (rd_data),
        .wb_en        (wb_en),
        .wb_id        (wb_id),
        .wb_data      (wb_data),
        .issue_valid  (issue_valid),
        .issue_has_rd (issue_has_rd),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .flush        (flush),
        .busy         (busy),
        .stall_cnt    (stall_cnt),
        .debug_reg    (debug_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rd_id        = '0;
        wb_en        = 1'b0;
        wb_id        = '0;
        wb_data      = '0;
        issue_valid  = 1'b0;
        issue_has_rd = 1'b0;
        issue_rd     = '0;
        flush        = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();

        // Reset state, and a writeback presented during reset must be dropped
        @(negedge clk);
        chk("rst_busy",  64'(busy), 64'h0);
        chk("rst_stall", 64'(stall_cnt), 64'h0);
        chk("rst_ready", 64'(issue_ready), 64'h1);
        chk("rst_rd0",   64'(rd_data[31:0]), 64'h0);
        wb_en = 1'b1; wb_id = 5'd5; wb_data = 32'h0000_0111;
        @(negedge clk);
        chk("rst_wb_drop", 64'(debug_reg[5*32 +: 32]), 64'h0);

        // Release reset; first edge afterwards writes x5, bypass visible now
        reset   = 1'b0;
        wb_data = 32'hDEAD_BEEF;
        rd_id   = {5'd0, 5'd5};
        #1;
        chk("byp_x5", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
        chk("byp_p1_x0", 64'(rd_data[63:32]), 64'h0);
        @(negedge clk);
        wb_en = 1'b0;
        #1;
        chk("held_x5", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
        chk("dbg_x5",  64'(debug_reg[5*32 +: 32]), 64'hDEAD_BEEF);

        // x0: write ignored, issue to x0 never busies it
        @(negedge clk);
        rd_id = '0;
        wb_en = 1'b1; wb_id = 5'd0; wb_data = 32'h0000_1234;
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd0;
        #1;
        chk("x0_rd",    64'(rd_data[31:0]), 64'h0);
        chk("x0_ready", 64'(issue_ready), 64'h1);
        @(negedge clk);
        idle();
        chk("x0_busy", 64'(busy), 64'h0);
        chk("x0_dbg",  64'(debug_reg[31:0]), 64'h0);

        // RAW: issue x7, dependant stalls, writeback releases it with bypass
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd7;
        #1;
        chk("i7_ready", 64'(issue_ready), 64'h1);
        @(negedge clk);
        chk("i7_busy", 64'(busy), 64'h80);
        issue_has_rd = 1'b0;
        rd_id = {5'd5, 5'd7};
        #1;
        chk("raw_ready", 64'(issue_ready), 64'h0);
        chk("raw_p1_x5", 64'(rd_data[63:32]), 64'hDEAD_BEEF);
        @(negedge clk);
        chk("raw_stall", 64'(stall_cnt), 64'h1);
        wb_en = 1'b1; wb_id = 5'd7; wb_data = 32'h0000_0055;
        #1;
        chk("raw_wb_ready", 64'(issue_ready), 64'h1);
        chk("raw_wb_byp",   64'(rd_data[31:0]), 64'h55);
        @(negedge clk);
        idle();
        chk("raw_busy_clr", 64'(busy), 64'h0);
        chk("raw_stall_hold", 64'(stall_cnt), 64'h1);
        chk("raw_dbg_x7", 64'(debug_reg[7*32 +: 32]), 64'h55);

        // WAW: busy x3, re-issue x3 held until a same-cycle writeback, bit stays set
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd3;
        @(negedge clk);
        chk("i3_busy", 64'(busy), 64'h8);
        #1;
        chk("waw_ready", 64'(issue_ready), 64'h0);
        wb_en = 1'b1; wb_id = 5'd3; wb_data = 32'hA5A5_0003;
        #1;
        chk("waw_wb_ready", 64'(issue_ready), 64'h1);
        @(negedge clk);
        idle();
        chk("waw_busy_kept", 64'(busy), 64'h8);
        chk("waw_dbg_x3", 64'(debug_reg[3*32 +: 32]), 64'hA5A5_0003);
        rd_id = {5'd0, 5'd3};
        #1;
        chk("waw_rd_x3", 64'(rd_data[31:0]), 64'hA5A5_0003);
        wb_en = 1'b1; wb_id = 5'd3; wb_data = 32'h0000_0033;
        rd_id = '0;
        @(negedge clk);
        idle();
        chk("x3_busy_clr", 64'(busy), 64'h0);
        chk("x3_dbg", 64'(debug_reg[3*32 +: 32]), 64'h33);

        // Flush: clears x4/x9, blocks the x2 issue, writeback still lands
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd4;
        @(negedge clk);
        issue_rd = 5'd9;
        @(negedge clk);
        chk("fl_busy_pre", 64'(busy), 64'h210);
        flush = 1'b1; issue_rd = 5'd2;
        wb_en = 1'b1; wb_id = 5'd4; wb_data = 32'h0000_0044;
        #1;
        chk("fl_ready", 64'(issue_ready), 64'h0);
        @(negedge clk);
        idle();
        chk("fl_busy", 64'(busy), 64'h0);
        chk("fl_dbg_x4", 64'(debug_reg[4*32 +: 32]), 64'h44);
        chk("fl_stall", 64'(stall_cnt), 64'h2);

        // Long stall on x7: 2^4+3 stalled cycles saturate a 4-bit counter
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd7;
        @(negedge clk);
        chk("st_busy", 64'(busy), 64'h80);
        issue_has_rd = 1'b0;
        rd_id = {5'd0, 5'd7};
        repeat (5) @(negedge clk);
        chk("st_mid", 64'(stall_cnt), 64'h7);
        repeat (14) @(negedge clk);
        chk("st_sat", 64'(stall_cnt), 64'hF);
        chk("st_ready", 64'(issue_ready), 64'h0);

        // Asynchronous reset mid-stall, away from any clock edge
        #2;
        reset = 1'b1;
        #1;
        chk("ar_stall", 64'(stall_cnt), 64'h0);
        chk("ar_busy",  64'(busy), 64'h0);
        chk("ar_dbg_x5", 64'(debug_reg[5*32 +: 32]), 64'h0);
        chk("ar_ready", 64'(issue_ready), 64'h1);
        @(negedge clk);
        reset = 1'b0;
        idle();
        wb_en = 1'b1; wb_id = 5'd9; wb_data = 32'h0000_0009;
        @(negedge clk);
        idle();
        chk("post_rst_wb", 64'(debug_reg[9*32 +: 32]), 64'h9);
        chk("post_rst_stall", 64'(stall_cnt), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
